// File: rtl/mem_bridge.sv
// mem_bridge: turns one 32-bit CPU load/store into four little-endian byte
// transfers on a byte bus, with a per-byte ack timeout and a sticky error flag.
module mem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  input  logic [7:0]  bus_rdata_i,
  input  logic        bus_ack_i
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_k;
  logic [3:0]  r_wait;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_we, r_err;
  logic        w_req, w_xfer;
  assign w_req  = mem_read_i | mem_write_i;
  assign w_xfer = r_state == XFER;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_req ? XFER : IDLE;
      XFER:    w_next = (bus_ack_i ? r_k == 2'd3 : r_wait == 4'hf) ? DONE : XFER;
      default: w_next = IDLE;
    endcase
  end
  assign busy_o      = w_xfer | (r_state == IDLE & w_req);
  assign bus_req_o   = w_xfer;
  assign bus_we_o    = w_xfer & r_we;
  assign bus_addr_o  = w_xfer ? r_addr + {30'b0, r_k} : '0;
  assign bus_wdata_o = w_xfer ? r_wdata[{r_k, 3'b000} +: 8] : '0;
  assign mem_data_o  = r_state == DONE ? r_rdata : '0;
  assign err_o       = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_wait  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_addr  <= mem_addr_i;
        r_wdata <= mem_data_i;
        r_we    <= mem_write_i;
        r_rdata <= '0;
        r_k     <= '0;
        r_wait  <= '0;
        if (mem_read_i & mem_write_i) r_err <= 1'b1;
      end else if (w_xfer && bus_ack_i) begin
        if (!r_we) r_rdata[{r_k, 3'b000} +: 8] <= bus_rdata_i;
        r_k    <= r_k + 2'd1;
        r_wait <= '0;
      end else if (w_xfer) begin
        // wait counter wraps to 0 on the aborting cycle, ready for the next transfer
        r_wait <= r_wait + 4'd1;
        if (r_wait == 4'hf) r_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed transactions against a byte-memory slave model with
// scoreboard queues for bus transfers and returned load words.
module tb_mem_bridge;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [31:0] mem_addr_i = '0, mem_data_i = '0;
  logic [31:0] mem_data_o, bus_addr_o;
  logic        busy_o, err_o, bus_req_o, bus_we_o, bus_ack_i;
  logic [7:0]  bus_wdata_o, bus_rdata_i;
  logic [7:0]  mem [256];
  int          ack_delay = 0, cnt = 0, total = 0, bad = 0;
  logic        hang_en = 1'b0;
  logic [31:0] hang_addr = '0;
  typedef struct {logic we; logic [31:0] addr; logic [7:0] wdata;} bus_t;
  bus_t        exp_q[$];
  bus_t        e;
  logic [31:0] exp_data_q[$];

  mem_bridge dut (
    .clk(clk), .rst(rst), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .busy_o(busy_o), .err_o(err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  assign bus_ack_i   = bus_req_o && cnt >= ack_delay && !(hang_en && bus_addr_o == hang_addr);
  assign bus_rdata_i = mem[bus_addr_o[7:0]];
  always @(posedge clk) cnt <= (bus_req_o && !bus_ack_i) ? cnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_req_o === 1'b1 && bus_ack_i === 1'b1) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : '{1'bx, 32'hx, 8'hx};
      chk("bus_addr", bus_addr_o, e.addr);
      chk("bus_we", {31'b0, bus_we_o}, {31'b0, e.we});
      if (e.we) chk("bus_wdata", {24'b0, bus_wdata_o}, {24'b0, e.wdata});
    end
  end

  task automatic txn(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] exp_word, input int nb,
                     input int exp_cyc, input logic exp_err);
    int   cyc = 0;
    bus_t b;
    for (int k = 0; k < nb; k++) begin
      b = '{wr, addr + 32'(k), data[8*k +: 8]};
      exp_q.push_back(b);
    end
    exp_data_q.push_back(exp_word);
    mem_read_i = rd; mem_write_i = wr; mem_addr_i = addr; mem_data_i = data;
    #1 chk({tag, "_busy0"}, {31'b0, busy_o}, 32'd1);
    do begin
      @(negedge clk);
      cyc++;
      mem_addr_i = $urandom;
      mem_data_i = $urandom;
      if (busy_o === 1'b1) chk({tag, "_mdata_busy"}, mem_data_o, 32'd0);
    end while (busy_o === 1'b1 && cyc < 40);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    chk({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_data"}, mem_data_o, exp_data_q.pop_front());
    chk({tag, "_err"}, {31'b0, err_o}, {31'b0, exp_err});
    chk({tag, "_req_done"}, {31'b0, bus_req_o}, 32'd0);
    @(negedge clk);
    chk({tag, "_mdata_idle"}, mem_data_o, 32'd0);
    chk({tag, "_busy_idle"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    bus_t b;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    mem[8'h20] = 8'hA1; mem[8'h21] = 8'hB2; mem[8'h22] = 8'hC3; mem[8'h23] = 8'hD4;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_we", {31'b0, bus_we_o}, 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_wdata", {24'b0, bus_wdata_o}, 32'd0);
    chk("rst_mdata", mem_data_o, 32'd0);
    rst = 1'b0;

    txn("rd100", 1, 0, 32'h100, 32'h0, 32'h44332211, 4, 5, 0);
    txn("wrwrap", 0, 1, 32'hFFFFFFFE, 32'hDEADBEEF, 32'h0, 4, 5, 0);
    mem[8'hFE] = 8'hEF; mem[8'hFF] = 8'hBE; mem[8'h00] = 8'hAD; mem[8'h01] = 8'hDE;
    ack_delay = 3;
    txn("rdslow", 1, 0, 32'hFFFFFFFE, 32'h0, 32'hDEADBEEF, 4, 17, 0);
    ack_delay = 0;
    hang_en = 1'b1; hang_addr = 32'h22;
    txn("tmo", 1, 0, 32'h20, 32'h0, 32'h0000B2A1, 2, 19, 1);
    hang_en = 1'b0;
    txn("after_tmo", 1, 0, 32'h100, 32'h0, 32'h4433DEAD, 4, 5, 1);

    b = '{1'b0, 32'h100, 8'h0}; exp_q.push_back(b);
    b = '{1'b0, 32'h101, 8'h0}; exp_q.push_back(b);
    mem_read_i = 1'b1; mem_addr_i = 32'h100;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_byte1", bus_addr_o, 32'h101);
    rst = 1'b1; mem_read_i = 1'b0;
    @(negedge clk);
    chk("rstmid_req", {31'b0, bus_req_o}, 32'd0);
    chk("rstmid_busy", {31'b0, busy_o}, 32'd0);
    chk("rstmid_err", {31'b0, err_o}, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_nodone_busy", {31'b0, busy_o}, 32'd0);
      chk("rstmid_nodone_data", mem_data_o, 32'd0);
      chk("rstmid_nodone_req", {31'b0, bus_req_o}, 32'd0);
    end

    txn("both", 1, 1, 32'h40, 32'h01020304, 32'h0, 4, 5, 1);
    mem[8'h40] = 8'h04; mem[8'h41] = 8'h03; mem[8'h42] = 8'h02; mem[8'h43] = 8'h01;
    txn("rdboth", 1, 0, 32'h40, 32'h0, 32'h01020304, 4, 5, 1);
    chk("bus_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
